// File: rtl/imem_loader.sv
// Program loader for a byte-wide instruction memory with a ten-byte combinational fetch port.
// Bytes stream in at ascending addresses; overflow aborts the load, and fetch is permitted only after a clean load.
module imem_loader #(
  parameter int unsigned MEM_BYTES = 2048,
  parameter int unsigned ADDR_W    = 12
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              s_valid,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              s_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err,
  output logic [ADDR_W-1:0] ld_len,
  output logic [7:0]        ld_sum,
  output logic              run,
  input  logic [63:0]       f_pc,
  output logic [79:0]       f_bytes,
  output logic              f_imem_er
);

  localparam int unsigned IDX_W   = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned N_FETCH = 10;

  // Each non-idle state owns exactly one status bit, so the status outputs are flop outputs.
  typedef enum logic [2:0] {
    ST_IDLE = 3'b000,
    ST_LOAD = 3'b001,
    ST_DONE = 3'b010,
    ST_ERR  = 3'b100
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [7:0]        sum_q, sum_d;
  logic              xfer;
  logic              full;
  logic              wr_en;

  logic [7:0] mem [MEM_BYTES];

  assign xfer  = s_valid & state_q[0];
  assign full  = (len_q == ADDR_W'(MEM_BYTES));
  assign wr_en = xfer & ~full;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    sum_d   = sum_q;
    case (state_q)
      ST_LOAD: begin
        if (xfer) begin
          if (full) begin
            state_d = ST_ERR;
          end else begin
            len_d = len_q + ADDR_W'(1);
            sum_d = sum_q ^ s_data;
            if (s_last) state_d = ST_DONE;
          end
        end
      end
      default: begin
        if (start) begin
          state_d = ST_LOAD;
          len_d   = '0;
          sum_d   = '0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      sum_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      sum_q   <= sum_d;
    end
  end

  // Memory is deliberately outside the reset domain so contents survive a reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[IDX_W'(len_q)] <= s_data;
  end

  assign s_ready = state_q[0];
  assign ld_busy = state_q[0];
  assign ld_done = state_q[1];
  assign ld_err  = state_q[2];
  assign run     = state_q[1];
  assign ld_len  = len_q;
  assign ld_sum  = sum_q;

  // 65-bit addresses keep f_pc+i near the top of the 64-bit space from wrapping into memory.
  for (genvar g = 0; g < N_FETCH; g++) begin : g_fetch
    logic [64:0] rd_addr;
    assign rd_addr = {1'b0, f_pc} + 65'(g);
    assign f_bytes[8*g +: 8] = (rd_addr < 65'(MEM_BYTES)) ? mem[IDX_W'(rd_addr)] : 8'h00;
  end

  assign f_imem_er = ~state_q[1] | (f_pc >= 64'(MEM_BYTES));

endmodule

// File: tb/tb_imem_loader.sv
// Directed-sequence bench for imem_loader with random program bytes scored against a load/memory model.
module tb_imem_loader;

  localparam int unsigned MEM = 2048;
  localparam int unsigned AW  = 12;

  localparam int M_IDLE = 0;
  localparam int M_LOAD = 1;
  localparam int M_DONE = 2;
  localparam int M_ERR  = 3;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic          s_valid;
  logic [7:0]    s_data;
  logic          s_last;
  logic          s_ready;
  logic          ld_busy;
  logic          ld_done;
  logic          ld_err;
  logic [AW-1:0] ld_len;
  logic [7:0]    ld_sum;
  logic          run;
  logic [63:0]   f_pc;
  logic [79:0]   f_bytes;
  logic          f_imem_er;

  imem_loader #(.MEM_BYTES(MEM), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .s_valid   (s_valid),
    .s_data    (s_data),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .ld_err    (ld_err),
    .ld_len    (ld_len),
    .ld_sum    (ld_sum),
    .run       (run),
    .f_pc      (f_pc),
    .f_bytes   (f_bytes),
    .f_imem_er (f_imem_er)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: what the memory holds and what the last load achieved.
  logic [7:0] ref_mem [MEM];
  int         m_st;
  int         m_len;
  logic [7:0] m_sum;

  int n_vec;
  int n_err;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_status(input string tag);
    chk({tag, "_busy"},  80'(ld_busy), 80'(m_st == M_LOAD));
    chk({tag, "_done"},  80'(ld_done), 80'(m_st == M_DONE));
    chk({tag, "_err"},   80'(ld_err),  80'(m_st == M_ERR));
    chk({tag, "_run"},   80'(run),     80'(m_st == M_DONE));
    chk({tag, "_ready"}, 80'(s_ready), 80'(m_st == M_LOAD));
    chk({tag, "_len"},   80'(ld_len),  80'(m_len));
    chk({tag, "_sum"},   80'(ld_sum),  80'(m_sum));
  endtask

  function automatic logic [79:0] exp_fetch(input logic [63:0] pc);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) begin
      if (pc < 64'(MEM) && 64'(i) < 64'(MEM) - pc) r[8*i +: 8] = ref_mem[11'(pc + 64'(i))];
    end
    return r;
  endfunction

  task automatic fetch_chk(input string tag, input logic [63:0] pc);
    f_pc = pc;
    #1;
    chk({tag, "_bytes"}, f_bytes, exp_fetch(pc));
    chk({tag, "_er"}, 80'(f_imem_er), 80'((m_st != M_DONE) || (pc >= 64'(MEM))));
    @(negedge clk);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (m_st != M_LOAD) begin
      m_st  = M_LOAD;
      m_len = 0;
      m_sum = 8'h00;
    end
  endtask

  // One byte offered for one cycle; the model applies the load rules only if loading.
  task automatic send(input logic [7:0] d, input logic last);
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    @(negedge clk);
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (m_st == M_LOAD) begin
      if (m_len == MEM) begin
        m_st = M_ERR;
      end else begin
        ref_mem[m_len] = d;
        m_len++;
        m_sum ^= d;
        if (last) m_st = M_DONE;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  logic [7:0] prog [12];
  logic [7:0] sum38;
  logic [7:0] b2049;

  initial begin
    prog = '{8'h30, 8'h10, 8'hF3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
    n_vec = 0; n_err = 0;
    rst_n = 1'b0; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; f_pc = '0;
    m_st = M_IDLE; m_len = 0; m_sum = 8'h00;

    // Reset, then idle with stray s_valid must stay idle.
    @(negedge clk);
    check_status("reset");
    @(negedge clk);
    rst_n = 1'b1;
    s_valid = 1'b1; s_data = 8'hAA; s_last = 1'b1;
    idle(3);
    s_valid = 1'b0; s_last = 1'b0;
    check_status("idle_hold");

    // Fill the whole memory, s_last on byte 2048.
    do_start();
    check_status("full_start");
    for (int i = 0; i < MEM; i++) send(8'($urandom), (i == MEM - 1));
    check_status("full_done");
    chk("full_len2048", 80'(ld_len), 80'(2048));
    fetch_chk("full_pc2044", 64'd2044);
    fetch_chk("full_pc2048", 64'd2048);
    fetch_chk("full_pc0", 64'd0);
    for (int k = 0; k < 4; k++) fetch_chk("full_rnd", 64'($urandom_range(0, 2100)));

    // Short program streamed back to back.
    do_start();
    for (int i = 0; i < 12; i++) send(prog[i], (i == 11));
    check_status("p38");
    chk("p38_len12", 80'(ld_len), 80'(12));
    sum38 = m_sum;
    fetch_chk("p38_pc0", 64'd0);
    f_pc = 64'd0;
    #1;
    chk("p38_byte0", 80'(f_bytes[7:0]), 80'(8'h30));
    @(negedge clk);

    // Same program with three idle cycles between bytes.
    do_start();
    for (int i = 0; i < 12; i++) begin
      send(prog[i], (i == 11));
      if (i != 11) idle(3);
    end
    check_status("p39");
    chk("p39_sum_same", 80'(ld_sum), 80'(sum38));
    fetch_chk("p39_pc0", 64'd0);
    fetch_chk("p39_pc2", 64'd2);

    // Overflow: 2049 bytes with no s_last and occasional gaps.
    do_start();
    for (int i = 0; i < MEM + 1; i++) begin
      if (i == MEM) b2049 = ~ref_mem[MEM-1];
      else b2049 = 8'($urandom);
      send(b2049, 1'b0);
      if ($urandom_range(0, 15) == 0) idle(int'($urandom_range(1, 3)));
    end
    check_status("ovf");
    chk("ovf_len2048", 80'(ld_len), 80'(2048));
    chk("ovf_run0", 80'(run), 80'(0));
    fetch_chk("ovf_pc2040", 64'd2040);
    send(8'h55, 1'b1);
    check_status("ovf_stay");

    // start during a load is ignored; fetch far above memory.
    do_start();
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
    do_start();
    for (int i = 0; i < 2; i++) send(8'($urandom), 1'b0);
    check_status("ign_start");
    chk("ign_len5", 80'(ld_len), 80'(5));
    send(8'($urandom), 1'b1);
    check_status("ign_done");
    fetch_chk("pc_allones", 64'hFFFF_FFFF_FFFF_FFFF);
    fetch_chk("pc_wrapzone", 64'hFFFF_FFFF_FFFF_FFFB);
    fetch_chk("pc_alias", 64'h0000_0001_0000_0000);
    fetch_chk("pc_low", 64'd3);

    // Asynchronous reset mid-load, then a one-byte reload.
    do_start();
    for (int i = 0; i < 5; i++) send(8'($urandom), 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    m_st = M_IDLE; m_len = 0; m_sum = 8'h00;
    check_status("arst");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);
    check_status("arst_idle");
    do_start();
    send(8'h00, 1'b1);
    check_status("reload");
    chk("reload_len1", 80'(ld_len), 80'(1));
    fetch_chk("reload_pc0", 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
